// File: rtl/ultrasonic_distance_sensor.sv
// ultrasonic_distance_sensor
//   Drives an HC-SR04-style ranger: issues a periodic trigger pulse, times
//   the echo high time in 1 us ticks and converts it to whole centimetres
//   (58 us per cm, round trip). A missing or over-long echo reports 1023
//   together with the timeout flag.
//
// Ports
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low reset
//   echo     : asynchronous echo input from the sensor
//   trig     : registered trigger pulse to the sensor
//   distance : last measured range in cm (1023 = timeout)
//   valid    : one-cycle strobe, coincident with a distance/timeout update
//   timeout  : last update was a timeout; held until the next update
module ultrasonic_distance_sensor #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_US  = 60_000,
  parameter int TIMEOUT_US = 30_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       echo,
  output logic       trig,
  output logic [9:0] distance,
  output logic       valid,
  output logic       timeout
);

  localparam int DIV      = CLK_FREQ / 1_000_000;
  localparam int TRIG_CLK = TRIG_US * DIV;
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TRG_W    = (TRIG_CLK > 1) ? $clog2(TRIG_CLK) : 1;
  localparam int PER_W    = $clog2(PERIOD_US + 1);
  localparam int TO_W     = $clog2(TIMEOUT_US + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TRG_W-1:0] TRG_LAST = TRG_W'(TRIG_CLK - 1);
  // The period counter starts at trigger fall, so the trigger width is
  // already spent; launching on the tick before the last count keeps the
  // rising edges exactly PERIOD_US * DIV clocks apart.
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_US - TRIG_US - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_US);

  localparam logic [5:0] SUB_LAST = 6'd57;
  localparam logic [9:0] CM_SAT   = 10'd1022;
  localparam logic [9:0] DIST_TO  = 10'd1023;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t state, state_d;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             echo_s1, echo_s2, echo_s3;
  logic             echo_rise, echo_fall;
  logic             kick;
  logic [TRG_W-1:0] trg_cnt;
  logic [PER_W-1:0] period_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             to_hit;
  logic [5:0]       sub_cnt;
  logic [9:0]       cm_cnt;
  logic             trig_end;
  logic             meas_start;

  logic             trig_d, valid_d, timeout_d;
  logic [9:0]       dist_d;

  // 1 us tick: registered wrap flag, high in the cycle the divider reads 0.
  // A trigger launched from IDLE therefore starts at the same divider phase
  // as the very first trigger after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      tick    <= (div_cnt == DIV_LAST);
    end
  end

  // Echo synchronizer; echo_s3 only serves edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_s3 <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
    end
  end

  assign echo_rise  = echo_s2 & ~echo_s3;
  assign echo_fall  = ~echo_s2 & echo_s3;
  assign to_hit     = (to_cnt == TO_LIMIT);
  assign trig_end   = (state == TRIG) && (state_d == WAIT_ECHO);
  assign meas_start = (state == WAIT_ECHO) && (state_d == MEASURE);

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      trig     <= 1'b0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      distance <= '0;
    end else begin
      state    <= state_d;
      trig     <= trig_d;
      valid    <= valid_d;
      timeout  <= timeout_d;
      distance <= dist_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (kick || (tick && period_cnt >= PER_LAST)) state_d = TRIG;
      TRIG:      if (trg_cnt == TRG_LAST) state_d = WAIT_ECHO;
      WAIT_ECHO: if (to_hit) state_d = DONE;
                 else if (echo_rise) state_d = MEASURE;
      MEASURE:   if (to_hit || echo_fall) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output logic, registered above so trig/valid/distance are glitch-free.
  // The result is latched on entry to DONE, the same edge that raises valid.
  // A timeout wins over an echo fall landing in the same cycle.
  always_comb begin
    trig_d    = (state_d == TRIG);
    valid_d   = (state_d == DONE);
    dist_d    = distance;
    timeout_d = timeout;
    if (state_d == DONE) begin
      if (to_hit) begin
        dist_d    = DIST_TO;
        timeout_d = 1'b1;
      end else begin
        dist_d    = cm_cnt;
        timeout_d = 1'b0;
      end
    end
  end

  // kick launches the first trigger straight out of reset without waiting
  // for a period to elapse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              kick <= 1'b1;
    else if (state == TRIG)  kick <= 1'b0;
  end

  // Trigger width is counted in clocks, not ticks, so it is exact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              trg_cnt <= '0;
    else if (state == TRIG)  trg_cnt <= trg_cnt + 1'b1;
    else                     trg_cnt <= '0;
  end

  // Period and timeout counters, both restarted at trigger fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
      to_cnt     <= '0;
    end else if (trig_end) begin
      period_cnt <= '0;
      to_cnt     <= '0;
    end else if (tick) begin
      if (state != TRIG && period_cnt != '1)
        period_cnt <= period_cnt + 1'b1;
      if ((state == WAIT_ECHO || state == MEASURE) && !to_hit)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  // Range counters. The rise-detect cycle already has echo high, so a tick
  // in that cycle is counted on entry; this makes the count equal to the
  // number of whole microseconds echo was high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_cnt <= '0;
      cm_cnt  <= '0;
    end else if (meas_start) begin
      sub_cnt <= tick ? 6'd1 : 6'd0;
      cm_cnt  <= '0;
    end else if (state == MEASURE && tick && echo_s2) begin
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        if (cm_cnt != CM_SAT) cm_cnt <= cm_cnt + 10'd1;
      end else begin
        sub_cnt <= sub_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_distance_sensor.sv
// Bench for ultrasonic_distance_sensor, scaled to 2 MHz / 3500 us period /
// 3000 us timeout so every cycle completes in a few thousand clocks.
module tb_ultrasonic_distance_sensor;

  localparam int DIV        = 2;
  localparam int TRIG_CLK   = 10 * DIV;
  localparam int PERIOD_CLK = 3500 * DIV;
  localparam int TO_CLK     = 3000 * DIV;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       echo  = 1'b0;
  logic       trig, valid, timeout;
  logic [9:0] distance;

  ultrasonic_distance_sensor #(
    .CLK_FREQ  (2_000_000),
    .TRIG_US   (10),
    .PERIOD_US (3500),
    .TIMEOUT_US(3000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .echo    (echo),
    .trig    (trig),
    .distance(distance),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   rise_cnt = 0, fall_cnt = 0, rise_cyc = 0, fall_cyc = 0;
  int   vcount = 0, vcyc = 0, vdist = 0, vto = 0;
  logic trig_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge
  always @(negedge clk) begin
    trig_q <= trig;
    if (trig && !trig_q) begin rise_cnt <= rise_cnt + 1; rise_cyc <= cyc; end
    if (!trig && trig_q) begin fall_cnt <= fall_cnt + 1; fall_cyc <= cyc; end
    if (valid) begin
      vcount <= vcount + 1;
      vcyc   <= cyc;
      vdist  <= int'(distance);
      vto    <= int'(timeout);
    end
  end

  typedef struct {
    string name;
    int    delay_us;  // echo start after trig fall
    int    echo_us;   // >0 pulse width, 0 no echo, <0 held high throughout
    int    exp_dist;
    int    exp_to;
  } vec_t;

  vec_t vecs[8];

  int total = 0, bad = 0;
  int seen_rise = 0, seen_fall = 0, prev_rise = 0;
  bit have_prev = 1'b0;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s: got=%0d expected %0d..%0d", nm, got, lo, hi);
    end
  endtask

  task automatic wait_rise();
    int n = 0;
    while (rise_cnt == seen_rise && n < 9000) begin @(posedge clk); #2; n++; end
    check("trig_rise_seen", int'(rise_cnt != seen_rise), 1);
    seen_rise = rise_cnt;
  endtask

  task automatic wait_fall();
    int n = 0;
    while (fall_cnt == seen_fall && n < 100) begin @(posedge clk); #2; n++; end
    check("trig_fall_seen", int'(fall_cnt != seen_fall), 1);
    seen_fall = fall_cnt;
  endtask

  task automatic wait_valid(input int v0);
    int n = 0;
    while (vcount == v0 && n < 8000) begin @(posedge clk); #2; n++; end
    check("valid_seen", int'(vcount != v0), 1);
  endtask

  task automatic run_vec(input int i);
    int v0;
    if (vecs[i].echo_us < 0) echo = 1'b1;
    wait_rise();
    if (have_prev) check({vecs[i].name, ":trig_period"}, rise_cyc - prev_rise, PERIOD_CLK);
    prev_rise = rise_cyc;
    have_prev = 1'b1;
    wait_fall();
    check({vecs[i].name, ":trig_width"}, fall_cyc - rise_cyc, TRIG_CLK);
    v0 = vcount;
    if (vecs[i].echo_us > 0) begin
      repeat (vecs[i].delay_us * DIV) @(posedge clk);
      #2 echo = 1'b1;
      repeat (vecs[i].echo_us * DIV) @(posedge clk);
      #2 echo = 1'b0;
    end
    wait_valid(v0);
    check({vecs[i].name, ":distance"}, vdist, vecs[i].exp_dist);
    check({vecs[i].name, ":timeout"}, vto, vecs[i].exp_to);
    if (vecs[i].exp_to != 0)
      check_rng({vecs[i].name, ":timeout_latency"}, vcyc - fall_cyc, TO_CLK, TO_CLK + 4);
    repeat (40) @(posedge clk);
    #2;
    check({vecs[i].name, ":valid_pulses"}, vcount - v0, 1);
    echo = 1'b0;
  endtask

  initial begin
    int v0;
    vecs[0] = '{"e580",  200,  580,   10, 0};
    vecs[1] = '{"e290",  100,  290,    5, 0};
    vecs[2] = '{"e57",   100,   57,    0, 0};
    vecs[3] = '{"e58",   100,   58,    1, 0};
    vecs[4] = '{"noecho",  0,    0, 1023, 1};
    vecs[5] = '{"held",    0,   -1, 1023, 1};
    vecs[6] = '{"e1160", 100, 1160,   20, 0};
    vecs[7] = '{"e2320", 100, 2320,   40, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst:trig",     int'(trig),     0);
    check("rst:valid",    int'(valid),    0);
    check("rst:distance", int'(distance), 0);
    check("rst:timeout",  int'(timeout),  0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
    check("rst:trig_first_edge", int'(trig), 1);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset 300 us into MEASURE: aborts with no strobe, outputs clear at once
    wait_rise();
    check("abort:trig_period", rise_cyc - prev_rise, PERIOD_CLK);
    wait_fall();
    v0 = vcount;
    repeat (100 * DIV) @(posedge clk);
    #2 echo = 1'b1;
    repeat (300 * DIV) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort:trig",     int'(trig),     0);
    check("abort:valid",    int'(valid),    0);
    check("abort:distance", int'(distance), 0);
    check("abort:timeout",  int'(timeout),  0);
    echo = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("abort:trig_held", int'(trig), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
    check("abort:trig_first_edge", int'(trig), 1);
    check("abort:no_valid", vcount - v0, 0);
    have_prev = 1'b0;

    for (int i = 6; i < 8; i++) run_vec(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
